id_ex_latch: RTL and testbench

- Decode/execute pipeline register; the consumer of the hazard unit's de_state command.
- Each cycle it advances, holds or squashes the decoded instruction as commanded.
- Publishes the registered destination (ex_wsel) back to the hazard unit for dependency checks.
- Keeps saturating stall and flush event counters for performance debug.

---
 rtl/cpu_types_pkg.sv | 37 +++
 rtl/id_ex_latch_if.sv | 43 ++++
 rtl/sat_counter.sv | 27 ++
 rtl/id_ex_latch.sv | 68 ++++++
 tb/tb_id_ex_latch.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: hazard-unit command encoding, register index and the
// latched control bundle with its capture-time sanitisation.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        PIPE_NORMAL  = 2'b00,
        PIPE_STALL   = 2'b01,
        PIPE_FLUSH   = 2'b10,
        PIPE_ILLEGAL = 2'b11
    } pipe_state_t;

    typedef logic [4:0] regbits_t;

    typedef struct packed {
        logic     valid;
        logic     regwen;
        logic     memren;
        logic     memwen;
        logic     halt;
        regbits_t wsel;
    } ex_ctrl_t;

    // Non-writers and $0 publish wsel=0 so the hazard unit can never match them.
    function automatic ex_ctrl_t sanitize_ctrl(input logic valid, input logic regwen,
                                               input logic memren, input logic memwen,
                                               input logic halt, input regbits_t wsel);
        ex_ctrl_t c;
        c.valid  = valid;
        c.regwen = valid & regwen & (wsel != '0);
        c.wsel   = c.regwen ? wsel : '0;
        c.memren = valid & memren;
        c.memwen = valid & memwen;
        c.halt   = valid & halt;
        return c;
    endfunction

endpackage

// File: rtl/id_ex_latch_if.sv
// Decode/execute latch bundle: hazard command, decoded fields in, registered
// fields and debug counters out.
import cpu_types_pkg::*;

interface id_ex_latch_if #(
    parameter int PAYLOAD_W = 128,
    parameter int CNT_W     = 16
);
    pipe_state_t            de_state;
    logic                   in_valid;
    regbits_t               in_wsel;
    logic                   in_regwen;
    logic                   in_memren;
    logic                   in_memwen;
    logic                   in_halt;
    logic [PAYLOAD_W-1:0]   in_payload;
    logic                   cnt_clr;

    logic                   ex_valid;
    regbits_t               ex_wsel;
    logic                   ex_regwen;
    logic                   ex_memren;
    logic                   ex_memwen;
    logic                   ex_halt;
    logic [PAYLOAD_W-1:0]   ex_payload;
    logic [CNT_W-1:0]       stall_cnt;
    logic [CNT_W-1:0]       flush_cnt;
    logic                   state_err;

    modport master (
        output de_state, in_valid, in_wsel, in_regwen, in_memren, in_memwen,
               in_halt, in_payload, cnt_clr,
        input  ex_valid, ex_wsel, ex_regwen, ex_memren, ex_memwen, ex_halt,
               ex_payload, stall_cnt, flush_cnt, state_err
    );

    modport slave (
        input  de_state, in_valid, in_wsel, in_regwen, in_memren, in_memwen,
               in_halt, in_payload, cnt_clr,
        output ex_valid, ex_wsel, ex_regwen, ex_memren, ex_memwen, ex_halt,
               ex_payload, stall_cnt, flush_cnt, state_err
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear that beats increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/id_ex_latch.sv
// Decode/execute pipeline register: advance, hold or squash per hazard command,
// plus stall/flush event counters and a sticky illegal-command flag.
import cpu_types_pkg::*;

module id_ex_latch #(
    parameter int PAYLOAD_W = 128,
    parameter int CNT_W     = 16
) (
    input  logic          CLK,
    input  logic          nRST,
    id_ex_latch_if.slave  bus
);
    ex_ctrl_t             ctrl_d, ctrl_q;
    logic [PAYLOAD_W-1:0] payload_d, payload_q;
    logic                 state_err_d, state_err_q;
    logic                 stall_inc, flush_inc;

    always_comb begin
        ctrl_d      = ctrl_q;
        payload_d   = payload_q;
        state_err_d = state_err_q | (bus.de_state == PIPE_ILLEGAL);
        case (bus.de_state)
            PIPE_NORMAL: begin
                ctrl_d    = sanitize_ctrl(bus.in_valid, bus.in_regwen, bus.in_memren,
                                          bus.in_memwen, bus.in_halt, bus.in_wsel);
                payload_d = bus.in_payload;
            end
            PIPE_FLUSH: begin
                ctrl_d    = '0;
                payload_d = '0;
            end
            default: ; // STALL and the illegal code both hold
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ctrl_q      <= '0;
            payload_q   <= '0;
            state_err_q <= 1'b0;
        end else begin
            ctrl_q      <= ctrl_d;
            payload_q   <= payload_d;
            state_err_q <= state_err_d;
        end
    end

    // Re-flushing a bubble is not a squashed instruction.
    assign stall_inc = (bus.de_state == PIPE_STALL);
    assign flush_inc = (bus.de_state == PIPE_FLUSH) & ctrl_q.valid;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .CLK(CLK), .nRST(nRST), .inc(stall_inc), .clr(bus.cnt_clr), .cnt(bus.stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .CLK(CLK), .nRST(nRST), .inc(flush_inc), .clr(bus.cnt_clr), .cnt(bus.flush_cnt)
    );

    assign bus.ex_valid   = ctrl_q.valid;
    assign bus.ex_wsel    = ctrl_q.wsel;
    assign bus.ex_regwen  = ctrl_q.regwen;
    assign bus.ex_memren  = ctrl_q.memren;
    assign bus.ex_memwen  = ctrl_q.memwen;
    assign bus.ex_halt    = ctrl_q.halt;
    assign bus.ex_payload = payload_q;
    assign bus.state_err  = state_err_q;
endmodule

// File: tb/tb_id_ex_latch.sv
// Randomized self-checking bench for id_ex_latch against a rule-level model.
import cpu_types_pkg::*;

module tb_id_ex_latch;
    localparam int PW   = 128;
    localparam int CW   = 16;
    localparam int CMAX = (1 << CW) - 1;

    logic CLK = 1'b0;
    logic nRST;
    int   n_chk  = 0;
    int   n_fail = 0;

    id_ex_latch_if #(.PAYLOAD_W(PW), .CNT_W(CW)) bus ();

    id_ex_latch #(.PAYLOAD_W(PW), .CNT_W(CW)) dut (
        .CLK(CLK), .nRST(nRST), .bus(bus)
    );

    always #5 CLK = ~CLK;

    // reference state
    logic          m_valid, m_regwen, m_memren, m_memwen, m_halt, m_err;
    logic [4:0]    m_wsel;
    logic [PW-1:0] m_payload;
    int            m_stall, m_flush;

    task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_regwen = 0; m_memren = 0; m_memwen = 0; m_halt = 0;
        m_err = 0; m_wsel = 0; m_payload = '0; m_stall = 0; m_flush = 0;
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ".valid"},  bus.ex_valid,   m_valid);
        check({ctx, ".wsel"},   bus.ex_wsel,    m_wsel);
        check({ctx, ".regwen"}, bus.ex_regwen,  m_regwen);
        check({ctx, ".memren"}, bus.ex_memren,  m_memren);
        check({ctx, ".memwen"}, bus.ex_memwen,  m_memwen);
        check({ctx, ".halt"},   bus.ex_halt,    m_halt);
        check({ctx, ".pay"},    bus.ex_payload, m_payload);
        check({ctx, ".scnt"},   bus.stall_cnt,  PW'(m_stall));
        check({ctx, ".fcnt"},   bus.flush_cnt,  PW'(m_flush));
        check({ctx, ".err"},    bus.state_err,  m_err);
    endtask

    // One clock: drive, let the edge happen, advance the model, optionally compare.
    task automatic step(input logic [1:0] st, input logic v, input logic [4:0] ws,
                        input logic rw, input logic mr, input logic mw, input logic h,
                        input logic [PW-1:0] p, input logic clr, input bit do_chk,
                        input string ctx);
        bus.de_state   = pipe_state_t'(st);
        bus.in_valid   = v;   bus.in_wsel   = ws;  bus.in_regwen = rw;
        bus.in_memren  = mr;  bus.in_memwen = mw;  bus.in_halt   = h;
        bus.in_payload = p;   bus.cnt_clr   = clr;
        @(posedge CLK);
        if (clr) begin
            m_stall = 0; m_flush = 0;
        end else begin
            if (st == 2'b01 && m_stall < CMAX) m_stall++;
            if (st == 2'b10 && m_valid && m_flush < CMAX) m_flush++;
        end
        if (st == 2'b11) m_err = 1;
        if (st == 2'b00) begin
            m_valid   = v;
            m_regwen  = v && rw && (ws != 0);
            m_wsel    = m_regwen ? ws : 5'd0;
            m_memren  = v && mr;
            m_memwen  = v && mw;
            m_halt    = v && h;
            m_payload = p;
        end else if (st == 2'b10) begin
            m_valid = 0; m_regwen = 0; m_memren = 0; m_memwen = 0; m_halt = 0;
            m_wsel = 0; m_payload = '0;
        end
        #1;
        if (do_chk) check_all(ctx);
    endtask

    function automatic logic [PW-1:0] rnd_pay();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic rnd_step(input logic [1:0] st, input logic clr, input string ctx);
        step(st, 1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), rnd_pay(), clr, 1, ctx);
    endtask

    logic [PW-1:0] pat;
    logic [1:0]    rst_st;

    initial begin
        pat = {16{8'hA5}};
        model_reset();
        nRST = 1'b0;
        bus.de_state = PIPE_NORMAL; bus.in_valid = 0; bus.in_wsel = 0; bus.in_regwen = 0;
        bus.in_memren = 0; bus.in_memwen = 0; bus.in_halt = 0; bus.in_payload = '0;
        bus.cnt_clr = 0;
        #12;
        check_all("reset");
        @(negedge CLK); nRST = 1'b1;

        step(2'b00, 1, 5'd8, 1, 0, 0, 0, pat, 0, 1, "norm8");
        step(2'b00, 1, 5'd0, 1, 1, 0, 1, ~pat, 0, 1, "norm0");
        step(2'b00, 0, 5'd7, 1, 1, 1, 1, pat, 0, 1, "bubble_in");

        step(2'b00, 1, 5'd9, 1, 0, 1, 0, pat, 0, 1, "load9");
        for (int i = 0; i < 3; i++) rnd_step(2'b01, 0, "stall");
        check("stall_cnt3", bus.stall_cnt, PW'(3));

        step(2'b00, 1, 5'd12, 1, 1, 0, 0, rnd_pay(), 0, 1, "preflush");
        rnd_step(2'b10, 0, "flush1");
        rnd_step(2'b10, 0, "flush2");
        check("flush_cnt1", bus.flush_cnt, PW'(1));

        step(2'b00, 1, 5'd3, 1, 0, 0, 0, rnd_pay(), 0, 1, "preillegal");
        rnd_step(2'b11, 0, "illegal");
        for (int i = 0; i < 3; i++) rnd_step(2'b00, 0, "post_illegal");
        check("err_sticky", bus.state_err, 1'b1);

        rnd_step(2'b01, 1, "clr_stall");
        check("clr_stall_cnt", bus.stall_cnt, PW'(0));

        for (int i = 0; i < 400; i++) begin
            int r;
            logic [1:0] st;
            r  = $urandom_range(0, 19);
            st = (r == 19) ? 2'b11 : 2'(r % 3);
            rnd_step(st, ($urandom_range(0, 39) == 0), "rand");
        end

        // async reset while a real instruction is held
        step(2'b00, 1, 5'd5, 1, 1, 1, 1, rnd_pay(), 0, 1, "prereset");
        #2 nRST = 1'b0;
        model_reset();
        #1 check_all("async_rst");
        @(negedge CLK); nRST = 1'b1;

        // drive the stall counter to the edge of saturation
        for (int i = 0; i < CMAX - 1; i++)
            step(2'b01, 0, 5'd0, 0, 0, 0, 0, '0, 0, 0, "bulk");
        check("stall_fffe", bus.stall_cnt, PW'(16'hFFFE));
        for (int i = 0; i < 3; i++) rnd_step(2'b01, 0, "sat");
        check("stall_ffff", bus.stall_cnt, PW'(16'hFFFF));
        rnd_step(2'b01, 1, "sat_clr");
        rst_st = 2'b00;
        rnd_step(rst_st, 0, "final");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
